// File: rtl/alu_mc_pkg.sv
// Shared opcode, FSM-state and status-flag definitions for the multi-cycle ALU.
package alu_mc_pkg;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_MUL  = 4'h2;
    localparam logic [3:0] ALU_DIV  = 4'h3;
    localparam logic [3:0] ALU_AND  = 4'h4;
    localparam logic [3:0] ALU_OR   = 4'h5;
    localparam logic [3:0] ALU_NAND = 4'h6;
    localparam logic [3:0] ALU_NOR  = 4'h7;
    localparam logic [3:0] ALU_XOR  = 4'h8;
    localparam logic [3:0] ALU_XNOR = 4'h9;
    localparam logic [3:0] ALU_CMP  = 4'hA;
    localparam logic [3:0] ALU_SHRA = 4'hB;
    localparam logic [3:0] ALU_SHLA = 4'hC;
    localparam logic [3:0] ALU_SHRB = 4'hD;
    localparam logic [3:0] ALU_SHLB = 4'hE;
    localparam logic [3:0] ALU_ILL  = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Bit positions inside the {Z,C,N,V} flags vector.
    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_mc_div.sv
// Restoring divider, one quotient bit per cycle. quotient/remainder show the
// result of the step being taken this cycle, so they are final while done=1.
module alu_mc_div #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    // Difference only matters when it fits, where it is below 2**WIDTH.
    always_comb begin
        shifted   = {rem_q, quo_q[WIDTH-1]};
        fits      = (shifted >= {1'b0, dvs_q});
        diff      = shifted[WIDTH-1:0] - dvs_q;
        remainder = fits ? diff : shifted[WIDTH-1:0];
        quotient  = {quo_q[WIDTH-2:0], fits};
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            busy  <= 1'b0;
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else if (start) begin
            count <= CW'(WIDTH - 1);
            busy  <= 1'b1;
            quo_q <= dividend;
            rem_q <= '0;
            dvs_q <= divisor;
        end else if (busy) begin
            quo_q <= quotient;
            rem_q <= remainder;
            count <= count - 1'b1;
            if (count == '0) busy <= 1'b0;
        end
    end

    assign done = busy && (count == '0);

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes, tag passthrough and iterative divide.
// Optional {Z,C,N,V} flags output enabled by defining ALU_MC_FLAGS_EN.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [3:0]         func,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic [TAG_W-1:0]   out_tag,
    output logic               err
`ifdef ALU_MC_FLAGS_EN
   ,output logic [3:0]         flags
`endif
);

    localparam int OUT_W = 2 * WIDTH;

    state_t           state, state_next;
    logic             accept, div_start;
    logic             div_busy, div_done;
    logic [WIDTH-1:0] div_quo, div_rem;
    logic [WIDTH:0]   sum, diff;
    logic [OUT_W-1:0] op_res;
    logic             op_err;

    assign accept    = in_valid && in_ready;
    assign div_start = accept && (func == ALU_DIV) && (b != '0);

    alu_mc_div #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .dividend  (a),
        .divisor   (b),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        op_res = '0;
        op_err = 1'b0;
        sum    = {1'b0, a} + {1'b0, b};
        diff   = {1'b0, a} - {1'b0, b};
        case (func)
            ALU_ADD:  op_res = OUT_W'(sum);
            ALU_SUB:  op_res = {{(OUT_W-WIDTH-1){diff[WIDTH]}}, diff};
            ALU_MUL:  op_res = OUT_W'(a) * OUT_W'(b);
            ALU_DIV: begin
                // Only reaches the output register for a zero divisor.
                op_res = {a, {WIDTH{1'b1}}};
                op_err = (b == '0);
            end
            ALU_AND:  op_res = {{WIDTH{1'b0}}, a & b};
            ALU_OR:   op_res = {{WIDTH{1'b0}}, a | b};
            ALU_NAND: op_res = {{WIDTH{1'b0}}, ~(a & b)};
            ALU_NOR:  op_res = {{WIDTH{1'b0}}, ~(a | b)};
            ALU_XOR:  op_res = {{WIDTH{1'b0}}, a ^ b};
            ALU_XNOR: op_res = {{WIDTH{1'b0}}, ~(a ^ b)};
            ALU_CMP:  op_res = (a == b) ? OUT_W'(0) : ((a > b) ? OUT_W'(1) : OUT_W'(2));
            ALU_SHRA: op_res = OUT_W'(a >> 1);
            ALU_SHLA: op_res = OUT_W'({a, 1'b0});
            ALU_SHRB: op_res = OUT_W'(b >> 1);
            ALU_SHLB: op_res = OUT_W'({b, 1'b0});
            default: begin
                op_res = '0;
                op_err = 1'b1;
            end
        endcase
    end

`ifdef ALU_MC_FLAGS_EN
    logic [3:0] op_flags, div_flags;

    always_comb begin
        op_flags         = '0;
        op_flags[FLAG_Z] = (op_res == '0);
        case (func)
            ALU_ADD: op_flags[FLAG_C] = sum[WIDTH];
            ALU_SUB: begin
                op_flags[FLAG_C] = diff[WIDTH];
                op_flags[FLAG_N] = diff[WIDTH];
            end
            ALU_MUL: op_flags[FLAG_V] = |op_res[OUT_W-1:WIDTH];
            default: ;
        endcase
        div_flags         = '0;
        div_flags[FLAG_Z] = ({div_rem, div_quo} == '0);
    end
`endif

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (accept) state_next = div_start ? ST_DIV : ST_HOLD;
            end
            ST_DIV: begin
                if (div_done)      state_next = ST_HOLD;
                else if (!div_busy) state_next = ST_IDLE;
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (accept)         state_next = div_start ? ST_DIV : ST_HOLD;
                else if (out_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_next;
    end

    // A tag loaded at a divide accept is invisible until the quotient lands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result  <= '0;
            out_tag <= '0;
            err     <= 1'b0;
`ifdef ALU_MC_FLAGS_EN
            flags   <= '0;
`endif
        end else begin
            if (accept) out_tag <= in_tag;
            if (accept && !div_start) begin
                result <= op_res;
                err    <= op_err;
`ifdef ALU_MC_FLAGS_EN
                flags  <= op_flags;
`endif
            end else if ((state == ST_DIV) && div_done) begin
                result <= {div_rem, div_quo};
                err    <= 1'b0;
`ifdef ALU_MC_FLAGS_EN
                flags  <= div_flags;
`endif
            end
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed vectors, a queue-based reference model
// and one compare process that checks every valid response cycle.
module tb_alu_mc;

    localparam int WIDTH = 8;
    localparam int TAG_W = 4;
    localparam int OUT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid, in_ready, out_valid, out_ready, err;
    logic [WIDTH-1:0] a, b;
    logic [3:0]       func;
    logic [TAG_W-1:0] in_tag, out_tag;
    logic [OUT_W-1:0] result;
`ifdef ALU_MC_FLAGS_EN
    logic [3:0]       flags;
`endif

    alu_mc #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .func      (func),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .out_tag   (out_tag),
        .err       (err)
`ifdef ALU_MC_FLAGS_EN
       ,.flags     (flags)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: returns {err, result} straight from the opcode definitions.
    function automatic logic [16:0] model(input logic [7:0] ma, input logic [7:0] mb, input logic [3:0] f);
        int          ia = int'(ma);
        int          ib = int'(mb);
        logic [15:0] r  = '0;
        logic        e  = 1'b0;
        case (f)
            4'h0: r = 16'(ia + ib);
            4'h1: r = 16'(ia - ib);
            4'h2: r = 16'(ia * ib);
            4'h3: begin
                if (ib == 0) begin
                    r = {ma, 8'hFF};
                    e = 1'b1;
                end else begin
                    r = {8'(ia % ib), 8'(ia / ib)};
                end
            end
            4'h4: r = {8'h00, ma & mb};
            4'h5: r = {8'h00, ma | mb};
            4'h6: r = {8'h00, ~(ma & mb)};
            4'h7: r = {8'h00, ~(ma | mb)};
            4'h8: r = {8'h00, ma ^ mb};
            4'h9: r = {8'h00, ~(ma ^ mb)};
            4'hA: r = (ia == ib) ? 16'd0 : ((ia > ib) ? 16'd1 : 16'd2);
            4'hB: r = 16'(ia / 2);
            4'hC: r = 16'(ia * 2);
            4'hD: r = 16'(ib / 2);
            4'hE: r = 16'(ib * 2);
            default: begin
                r = 16'd0;
                e = 1'b1;
            end
        endcase
        return {e, r};
    endfunction

    typedef struct {
        logic [15:0] res;
        logic [3:0]  tag;
        logic        err;
    } resp_t;

    resp_t exp_q[$];
    int    cur_run = 0;
    int    max_run = 0;

    // Every cycle with out_valid, the head of the expected queue must be on the outputs.
    always @(negedge clk) begin
        if (rst && out_valid) begin
            cur_run++;
            if (cur_run > max_run) max_run = cur_run;
            if (exp_q.size() == 0) begin
                check("response with nothing pending", exp_q.size(), 1);
            end else begin
                check("result", result, exp_q[0].res);
                check("out_tag", out_tag, exp_q[0].tag);
                check("err", err, exp_q[0].err);
                if (out_ready) void'(exp_q.pop_front());
            end
        end else begin
            cur_run = 0;
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic [3:0] tf, input logic [3:0] tt);
        logic        ok;
        logic [16:0] m;
        ok       = 1'b0;
        a        = ta;
        b        = tb;
        func     = tf;
        in_tag   = tt;
        in_valid = 1'b1;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("accept within budget", ok, 1);
        if (ok) begin
            m = model(ta, tb, tf);
            exp_q.push_back('{res: m[15:0], tag: tt, err: m[16]});
        end
    endtask

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic [3:0] vf;
    } vec_t;

    vec_t vecs [0:11];

    initial begin
        int cnt;
        logic seen;

        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        func      = '0;
        in_tag    = '0;
        out_ready = 1'b1;

        vecs = '{'{8'd3,   8'd5,   4'h1}, '{8'd9,   8'd4,   4'h1},
                 '{8'hF0,  8'h3C,  4'h4}, '{8'hF0,  8'h3C,  4'h5},
                 '{8'hF0,  8'h3C,  4'h6}, '{8'hF0,  8'h3C,  4'h7},
                 '{8'hF0,  8'h3C,  4'h8}, '{8'hF0,  8'h3C,  4'h9},
                 '{8'd7,   8'd7,   4'hA}, '{8'd5,   8'd9,   4'hA},
                 '{8'h81,  8'h81,  4'hC}, '{8'h81,  8'h03,  4'hE}};

        // Pin the model itself with hand-computed values.
        check("model add 200+100", model(8'd200, 8'd100, 4'h0), 17'h0012C);
        check("model sub 3-5",     model(8'd3,   8'd5,   4'h1), 17'h0FFFE);
        check("model div 200/7",   model(8'd200, 8'd7,   4'h3), 17'h0041C);
        check("model div 5/0",     model(8'd5,   8'd0,   4'h3), 17'h105FF);
        check("model nand",        model(8'hF0,  8'h3C,  4'h6), 17'h000CF);
        check("model cmp 5<9",     model(8'd5,   8'd9,   4'hA), 17'h00002);
        check("model shl b",       model(8'h00,  8'h81,  4'hE), 17'h00102);
        check("model illegal",     model(8'd1,   8'd2,   4'hF), 17'h10000);

        repeat (2) @(negedge clk);
        check("reset out_valid", out_valid, 0);
        check("reset result", result, 0);
        check("reset out_tag", out_tag, 0);
        check("reset err", err, 0);
        check("reset in_ready", in_ready, 1);
`ifdef ALU_MC_FLAGS_EN
        check("reset flags", flags, 0);
`endif
        rst = 1'b1;
        @(posedge clk);
        #1;

        send(8'd200, 8'd100, 4'h0, 4'd3);
        check("add valid after 1 cycle", out_valid, 1);
        check("add result", result, 16'h012C);
        check("add tag", out_tag, 4'd3);
`ifdef ALU_MC_FLAGS_EN
        check("add flags C", flags, 4'b0100);
`endif

        send(8'd200, 8'd7, 4'h3, 4'd5);
        cnt  = 0;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
            else if (!in_ready) cnt++;
        end
        check("div response seen", seen, 1);
        check("div busy cycles", cnt, 8);
        check("div result", result, 16'h041C);
        @(posedge clk);
        #1;

        send(8'd5, 8'd0, 4'h3, 4'd6);
        check("div0 valid next cycle", out_valid, 1);
        check("div0 result", result, 16'h05FF);
        check("div0 err", err, 1);
        @(posedge clk);
        #1;

        out_ready = 1'b0;
        send(8'd255, 8'd255, 4'h2, 4'd7);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            check("mul held in_ready", in_ready, 0);
            check("mul held result", result, 16'hFE01);
        end
`ifdef ALU_MC_FLAGS_EN
        check("mul flags V", flags, 4'b0001);
`endif
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("mul released to idle", out_valid, 0);
        check("idle in_ready", in_ready, 1);

        max_run = 0;
        for (int i = 0; i < 4; i++) send(8'(10 * i), 8'(i + 1), 4'h0, 4'(8 + i));
        repeat (2) @(posedge clk);
        #1;
        check("back-to-back valid run", max_run, 4);

        foreach (vecs[i]) send(vecs[i].va, vecs[i].vb, vecs[i].vf, 4'(i));
        send(8'd1, 8'd2, 4'hF, 4'd15);
        check("illegal err", err, 1);
        check("illegal result", result, 0);
        repeat (2) @(posedge clk);
        #1;

        send(8'd100, 8'd3, 4'h3, 4'd12);
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("reset mid-divide out_valid", out_valid, 0);
        check("reset mid-divide in_ready", in_ready, 1);
        exp_q.delete();
        @(negedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        send(8'd9, 8'd4, 4'h0, 4'd13);
        check("post-reset add result", result, 16'h000D);
        repeat (3) @(posedge clk);
        #1;
        check("all responses drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
